// File: rtl/byte_queue.sv
// Eight-entry byte FIFO behind the deserializer: level-request / one-cycle-ack capture, registered pop output.
// Write accepted the edge after a request in IDLE (ack next cycle), pop data valid the cycle after the dequeue edge; full holds the request pending.
`timescale 1ns/1ps
module byte_queue #(
    parameter int DEPTH = 8,
    parameter int WIDTH = 8
) (
    input  logic                     clock_10KHZ,
    input  logic                     reset,
    input  logic [WIDTH-1:0]         data_in,
    input  logic                     enqueue_in,
    output logic                     ack_out,
    input  logic                     dequeue_in,
    output logic [WIDTH-1:0]         data_out,
    output logic [$clog2(DEPTH):0]   len_out,
    output logic                     full_out,
    output logic                     empty_out
);

    localparam int AW = $clog2(DEPTH);
    localparam logic [AW:0] FULL_LEN = (AW+1)'(DEPTH);

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        ACK      = 2'd1,
        WAIT_LOW = 2'd2
    } state_t;

    state_t            state;
    logic [WIDTH-1:0]  mem [DEPTH];
    logic [AW-1:0]     wr_ptr;
    logic [AW-1:0]     rd_ptr;
    logic [AW:0]       len;
    logic              wr_en;
    logic              rd_en;

    // Full is judged on the pre-edge count, so a same-edge pop cannot make room for a write.
    assign wr_en = (state == IDLE) && enqueue_in && (len != FULL_LEN);
    assign rd_en = dequeue_in && (len != '0);

    always_ff @(posedge clock_10KHZ or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            ack_out <= 1'b0;
            wr_ptr  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (wr_en) begin
                        wr_ptr  <= wr_ptr + 1'b1;
                        ack_out <= 1'b1;
                        state   <= ACK;
                    end
                end
                ACK: begin
                    ack_out <= 1'b0;
                    state   <= WAIT_LOW;
                end
                WAIT_LOW: begin
                    // Request must be seen low once so one byte is never written twice.
                    if (!enqueue_in) state <= IDLE;
                end
                default: begin
                    ack_out <= 1'b0;
                    state   <= IDLE;
                end
            endcase
        end
    end

    always_ff @(posedge clock_10KHZ) begin
        if (wr_en) mem[wr_ptr] <= data_in;
    end

    always_ff @(posedge clock_10KHZ or negedge reset) begin
        if (!reset) begin
            rd_ptr   <= '0;
            data_out <= '0;
        end else if (rd_en) begin
            data_out <= mem[rd_ptr];
            rd_ptr   <= rd_ptr + 1'b1;
        end
    end

    always_ff @(posedge clock_10KHZ or negedge reset) begin
        if (!reset) begin
            len <= '0;
        end else begin
            case ({wr_en, rd_en})
                2'b10:   len <= len + 1'b1;
                2'b01:   len <= len - 1'b1;
                default: len <= len;
            endcase
        end
    end

    assign len_out   = len;
    assign full_out  = (len == FULL_LEN);
    assign empty_out = (len == '0);

endmodule

// File: doc/byte_queue.md
# byte_queue

Eight-entry, 8-bit FIFO that sits directly downstream of the serial-to-byte deserializer. It captures each completed byte with a level-request / one-cycle-acknowledge handshake and frees the deserializer for the next byte. It then holds bytes until the consumer pops them. Occupancy is reported for status display.

## Interface
Parameters:
- DEPTH, 8, number of entries; must be a power of two, at least 2.
- WIDTH, 8, data width in bits.

Ports:
- clock_10KHZ  in  1  sole clock; all state updates on its rising edge.
- reset  in  1  asynchronous, active-low (0 = reset); one clock, reset asynchronous active-low.
- data_in  in  WIDTH  byte from deserializer; valid while enqueue_in = 1.
- enqueue_in  in  1  write request, level; driven by deserializer data_ready.
- ack_out  out  1  one-cycle pulse confirming data_in was stored; drives deserializer ack_in.
- dequeue_in  in  1  pop request, sampled each edge; a pulse of N cycles pops N entries.
- data_out  out  WIDTH  last popped byte; registered, held until next successful pop.
- len_out  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full_out  out  1  len_out == DEPTH.
- empty_out  out  1  len_out == 0.

## Operation
- Storage: DEPTH x WIDTH memory. Write pointer and read pointer are each $clog2(DEPTH) bits and wrap modulo DEPTH naturally. A separate occupancy counter len holds values 0..DEPTH; full and empty are derived from len only.
- Write FSM states:
  - IDLE: if enqueue_in = 1 and len < DEPTH, write data_in at wr_ptr, increment wr_ptr, set ack_out <= 1, go to ACK. If full, stay in IDLE with no ack; the request stays pending.
  - ACK: ack_out <= 0; go to WAIT_LOW unconditionally.
  - WAIT_LOW: no writes. Go to IDLE on the first edge that samples enqueue_in = 0.
  - WAIT_LOW exists because the deserializer drops data_ready one cycle after seeing ack. This rules out duplicate writes of one byte.
- Read: on an edge with dequeue_in = 1 and len > 0:
  - data_out <= mem[rd_ptr];
  - rd_ptr increments.
- Dequeue with len = 0 is ignored: data_out, rd_ptr and len are unchanged.
- Occupancy update:
  - len + 1 on write only.
  - len - 1 on read only.
  - Unchanged when a write and a read both occur on the same edge, or when neither occurs.
  - Simultaneous write and read are allowed in every state. This includes full (read frees space only after the edge, so a write is not accepted on that edge) and empty (the write lands; the read is ignored because len = 0 at that edge).
- Reset (asserted at any time, including mid-handshake):
  - State IDLE; pointers 0; len 0.
  - ack_out 0, data_out 0, len_out 0, full_out 0, empty_out 1.
  - Memory contents are not cleared.
  - After release, a still-high enqueue_in is accepted as a new byte.

## Timing
- Write latency: the request is sampled at edge k. ack_out is high for exactly the cycle after edge k. len_out reflects the write after edge k.
- Minimum spacing between accepted writes: 3 edges (IDLE -> ACK -> WAIT_LOW -> IDLE), provided enqueue_in falls within 1 cycle of ack.
- Read latency: data_out is valid the cycle after the dequeue edge.
- full_out and empty_out are registered alongside len (or decoded combinationally from registered len). Either way they must match len_out in the same cycle.
- ack_out is never high for 2 consecutive cycles.

## Test plan
- Reset then idle: reset = 0 for 2 cycles, release. Expect ack_out = 0, data_out = 0x00, len_out = 0, empty_out = 1, full_out = 0.
- Single byte: enqueue_in = 1 with data_in = 0xA5, held until 1 cycle after ack. Expect exactly one ack pulse and len_out = 1. Then a 1-cycle dequeue_in gives data_out = 0xA5, len_out = 0, empty_out = 1.
- Fill and order: push 0x01..0x08 via handshake. Expect len_out = 8 and full_out = 1. A 9th request (0x09) held high gets no ack. One dequeue gives data_out = 0x01; then 0x09 is acked and len_out = 8. Eight pops return 0x02..0x09 in order, exercising pointer wrap.
- Pop on empty: dequeue_in = 1 for 3 cycles at len 0. Expect data_out to keep its previous value, len_out = 0, and no underflow.
- Simultaneous: at len = 3, a write edge coincides with a dequeue edge. Expect len_out to stay 3, data_out = oldest byte, and the new byte appended at the tail.
- Reset mid-handshake: assert reset during the ACK state. Expect ack_out = 0 immediately (asynchronous) and len_out = 0. After release with enqueue_in still high, expect a fresh ack and len_out = 1.
